// File: rtl/uart_rx_pkg.sv
// Shared constants and config clamp helpers for the UART receiver bit timer.
package uart_rx_pkg;

  localparam int unsigned UART_MIN_PRESCALE      = 4;
  localparam int unsigned UART_MIN_FRAME_LEN     = 2;
  localparam int unsigned UART_DEFAULT_PRESCALE  = 8;
  localparam int unsigned UART_DEFAULT_FRAME_LEN = 10;

  // A ratio below 4 cannot fit a three-edge sample window away from the bit edges.
  function automatic int unsigned clamp_prescale(input int unsigned value);
    return (value < UART_MIN_PRESCALE) ? UART_MIN_PRESCALE : value;
  endfunction

  function automatic int unsigned clamp_frame_len(input int unsigned value);
    return (value < UART_MIN_FRAME_LEN) ? UART_MIN_FRAME_LEN : value;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_timer_if.sv
// Config and strobe bundle between the RX FSM / sampler (master) and the bit timer (slave).
interface uart_rx_edge_bit_timer_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);

  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_len;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  sample_en;
  logic                  bit_done;
  logic                  frame_done;

  modport master (
    output en, prescale, frame_len,
    input  edge_count, bit_count, sample_en, bit_done, frame_done
  );

  modport slave (
    input  en, prescale, frame_len,
    output edge_count, bit_count, sample_en, bit_done, frame_done
  );

endinterface

// File: rtl/uart_wrap_counter.sv
// Up-counter with synchronous clear and a runtime terminal value; o_wrap flags the
// enabled cycle on which the count returns to zero.
module uart_wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = i_en && (r_count == i_last);
  assign o_count = r_count;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the two chained counters see a consistent snapshot of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_edge_bit_timer.sv
// Oversampling edge/bit timer for the UART receiver: sample-window strobes, bit-end
// strobe and a registered frame-done pulse, with config frozen while en is high.
module uart_rx_edge_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W        = 6,
  parameter int unsigned BIT_CNT_W         = 4,
  parameter int unsigned DEFAULT_PRESCALE  = UART_DEFAULT_PRESCALE,
  parameter int unsigned DEFAULT_FRAME_LEN = UART_DEFAULT_FRAME_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_edge_bit_timer_if.slave  tmr
);

  logic [PRESCALE_W-1:0] r_prescale_q;
  logic [BIT_CNT_W-1:0]  r_frame_len_q;
  logic                  r_frame_done;

  logic [PRESCALE_W-1:0] w_edge_last;
  logic [PRESCALE_W-1:0] w_mid;
  logic [PRESCALE_W-1:0] w_edge_count;
  logic [BIT_CNT_W-1:0]  w_bit_last;
  logic [BIT_CNT_W-1:0]  w_bit_count;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_clr;

  // Config tracks the inputs whenever idle and is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale_q  <= PRESCALE_W'(DEFAULT_PRESCALE);
      r_frame_len_q <= BIT_CNT_W'(DEFAULT_FRAME_LEN);
    end else if (!tmr.en) begin
      r_prescale_q  <= PRESCALE_W'(clamp_prescale(32'(tmr.prescale)));
      r_frame_len_q <= BIT_CNT_W'(clamp_frame_len(32'(tmr.frame_len)));
    end
  end

  assign w_clr       = !tmr.en;
  assign w_edge_last = r_prescale_q - PRESCALE_W'(1);
  assign w_bit_last  = r_frame_len_q - BIT_CNT_W'(1);
  assign w_mid       = r_prescale_q >> 1;

  uart_wrap_counter #(.W(PRESCALE_W)) u_edge_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (tmr.en),
    .i_clr   (w_clr),
    .i_last  (w_edge_last),
    .o_count (w_edge_count),
    .o_wrap  (w_bit_end)
  );

  uart_wrap_counter #(.W(BIT_CNT_W)) u_bit_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_bit_end),
    .i_clr   (w_clr),
    .i_last  (w_bit_last),
    .o_count (w_bit_count),
    .o_wrap  (w_frame_end)
  );

  // w_frame_end already requires en, so dropping en on the last edge yields no pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
    end
  end

  // Clamp keeps mid >= 2, so mid-1 never underflows and mid+1 always fits.
  assign tmr.sample_en  = tmr.en && ((w_edge_count == w_mid - PRESCALE_W'(1)) ||
                                     (w_edge_count == w_mid) ||
                                     (w_edge_count == w_mid + PRESCALE_W'(1)));
  assign tmr.bit_done   = w_bit_end;
  assign tmr.edge_count = w_edge_count;
  assign tmr.bit_count  = w_bit_count;
  assign tmr.frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_rx_edge_bit_timer.sv
// Directed self-checking bench for uart_rx_edge_bit_timer: nominal, sample window,
// freeze/clamp, abort, back-to-back and asynchronous reset.
module tb_uart_rx_edge_bit_timer;

  localparam int unsigned PW = 6;
  localparam int unsigned BW = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_edge_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_edge_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk (clk),
    .rst (rst_n),
    .tmr (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs after k enabled edges from a cleared start with ratio p, length f.
  task automatic expect_state(input string tag, input int k, input int p, input int f);
    int kk;
    int e;
    int mid;
    kk  = k % (p * f);
    e   = kk % p;
    mid = p / 2;
    check($sformatf("%s k=%0d edge", tag, k), bus.edge_count, e);
    check($sformatf("%s k=%0d bit", tag, k), bus.bit_count, kk / p);
    check($sformatf("%s k=%0d bit_done", tag, k), bus.bit_done, (e == p - 1) ? 1 : 0);
    check($sformatf("%s k=%0d sample_en", tag, k), bus.sample_en,
          (e >= mid - 1 && e <= mid + 1) ? 1 : 0);
    check($sformatf("%s k=%0d frame_done", tag, k), bus.frame_done,
          (k > 0 && (k % (p * f)) == 0) ? 1 : 0);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " edge"}, bus.edge_count, 0);
    check({tag, " bit"}, bus.bit_count, 0);
    check({tag, " bit_done"}, bus.bit_done, 0);
    check({tag, " sample_en"}, bus.sample_en, 0);
    check({tag, " frame_done"}, bus.frame_done, 0);
  endtask

  // One idle edge loads the config, then en rises just after that edge.
  task automatic start(input int p_in, input int f_in);
    bus.en        = 1'b0;
    bus.prescale  = PW'(p_in);
    bus.frame_len = BW'(f_in);
    @(posedge clk);
    #1;
    bus.en = 1'b1;
  endtask

  task automatic run(input string tag, input int p, input int f, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      #1;
      expect_state(tag, k, p, f);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.prescale  = PW'(8);
    bus.frame_len = BW'(10);
    #12;
    expect_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    start(8, 10);
    run("nominal", 8, 10, 0, 81);

    start(16, 2);
    run("sample16", 16, 2, 0, 33);
    start(5, 3);
    run("sample5", 5, 3, 0, 16);

    start(8, 10);
    run("freeze_a", 8, 10, 0, 20);
    bus.prescale = PW'(16);
    run("freeze_b", 8, 10, 20, 61);
    start(16, 10);
    run("reload16", 16, 10, 0, 17);

    start(2, 1);
    run("clamp", 4, 2, 0, 17);

    start(8, 10);
    run("abort_run", 8, 10, 0, 29);
    #1;
    expect_state("abort_pre", 29, 8, 10);
    bus.en = 1'b0;
    tick();
    expect_idle("abort_post");
    tick();
    check("abort_post2 frame_done", bus.frame_done, 0);

    start(4, 2);
    run("endabort_run", 4, 2, 0, 7);
    bus.en = 1'b0;
    tick();
    expect_idle("endabort_post");
    tick();
    check("endabort_post2 frame_done", bus.frame_done, 0);

    start(8, 10);
    run("b2b", 8, 10, 0, 161);

    start(8, 10);
    run("pre_rst", 8, 10, 0, 13);
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("async_rst");
    bus.prescale  = PW'(16);
    bus.frame_len = BW'(3);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 8, 10, 0, 81);

    bus.en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_edge_bit_timer.md
# uart_rx_edge_bit_timer

Parametrised oversampling timer for the UART receiver: counts oversampling edges within each bit and bits within each frame. The oversampling ratio and frame length are runtime-programmable and frozen while a frame is in progress. It emits sample-window strobes for majority-vote data sampling, a bit-end strobe and a frame-done pulse. It sits between the RX FSM, which drives `en`, and the data sampler / deserializer, which consume the strobes and counts.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_count`; max ratio 2^PRESCALE_W-1.
- `BIT_CNT_W`, 4: width of `frame_len` and `bit_count`.
- `DEFAULT_PRESCALE`, 8: reset value of latched prescale.
- `DEFAULT_FRAME_LEN`, 10: reset value of latched frame length.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: count enable from RX FSM; low = idle/clear.
- `prescale` in PRESCALE_W: oversampling ratio (edges per bit).
- `frame_len` in BIT_CNT_W: bits per frame including start, parity and stop.
- `edge_count` out PRESCALE_W: registered edge index within the current bit.
- `bit_count` out BIT_CNT_W: registered bit index within the current frame.
- `sample_en` out 1: high on the three centre edges of a bit.
- `bit_done` out 1: high on the last edge of a bit.
- `frame_done` out 1: registered one-cycle pulse at frame end.

## Operation
- Latched config `prescale_q`, `frame_len_q`:
  - Load from inputs on every clock where `en`=0; hold while `en`=1.
  - Clamp on load: `prescale` < 4 loads 4; `frame_len` < 2 loads 2.
- `en`=0: `edge_count`<=0, `bit_count`<=0 synchronously (the clear is not combinational).
- `en`=1 and `edge_count` != `prescale_q`-1: `edge_count`<=`edge_count`+1.
- `en`=1 and `edge_count` == `prescale_q`-1 (bit end):
  - `edge_count`<=0.
  - If `bit_count` == `frame_len_q`-1: `bit_count`<=0 and `frame_done`<=1 (frame end).
  - Otherwise: `bit_count`<=`bit_count`+1.
- `frame_done`<=0 on every clock that is not a frame end.
- Back-to-back frames: if `en` stays high through a frame end, counting continues from 0/0 with no idle cycle. Config stays frozen until `en` drops.
- `mid` = `prescale_q`>>1 (floor).
- `sample_en` = `en` && `edge_count` ∈ {mid-1, mid, mid+1}. Combinational decode of registered state.
- `bit_done` = `en` && `edge_count` == `prescale_q`-1. Combinational.
- Arithmetic: all compares at full counter width; no counter ever exceeds `prescale_q`-1 or `frame_len_q`-1, so there is no natural overflow.
- `en` deasserted mid-frame: counters clear on the next edge, no `frame_done`, config reloads.
- `en` deasserted on the frame-end edge itself: the en=0 clear wins and `frame_done` stays 0.

## Timing
- Reset values: `edge_count`=0, `bit_count`=0, `frame_done`=0, `prescale_q`=DEFAULT_PRESCALE, `frame_len_q`=DEFAULT_FRAME_LEN. `sample_en` and `bit_done` are 0 because they follow state and `en`.
- Reset asserted mid-frame: immediate return to reset values; no pulse is generated.
- With `en` rising at edge 0: `edge_count` reads k after k enabled edges.
- `bit_done` is high during the cycle in which `edge_count`=`prescale_q`-1.
- `frame_done` is high for exactly one cycle: the cycle after the frame-end edge, coincident with `edge_count`=0 and `bit_count`=0.
- Frame length is `prescale_q`×`frame_len_q` enabled cycles.

## Structure
- Shared package `uart_rx_pkg`:
  - Constants `UART_MIN_PRESCALE`=4 and `UART_MIN_FRAME_LEN`=2.
  - Default prescale and frame length values.
  - Clamp helper functions.
- One sub-module is natural: `uart_wrap_counter`, a parametrised-width counter with enable, synchronous clear and runtime terminal value, exposing a wrap flag.
  - Instantiated twice: edge counter, and bit counter advanced by its wrap flag.

## Test plan
- Nominal: prescale=8, frame_len=10, `en` held 80 cycles → `edge_count` cycles 0..7, `bit_count` steps 0..9, `bit_done` every 8th cycle, single `frame_done` at cycle 80 with counts 0/0.
- Sample window: prescale=16 → `sample_en` at edge_count 7,8,9 of every bit. Prescale=5 → `sample_en` at 1,2,3 (mid=2).
- Config freeze and clamp:
  - Change `prescale` 8→16 mid-frame → the period stays 8 until `en` drops.
  - `prescale`=2, `frame_len`=1 → behaves as 4 and 2, giving `frame_done` after 8 cycles.
- Abort: drop `en` at `bit_count`=3, `edge_count`=5 → next cycle 0/0, no `frame_done`. Drop `en` on the frame-end edge → no `frame_done`.
- Back-to-back: `en` held 2×80 cycles → two `frame_done` pulses exactly 80 cycles apart, with no gap.
- Reset: assert `rst` low asynchronously mid-bit → all outputs at reset values before the next clock edge. Release → `prescale_q`=8, `frame_len_q`=10.
